// File: rtl/debouncer_hyst.sv
// ---------------------------------------------------------------------------
// debouncer_hyst
//
// Multi-channel debouncer for raw board inputs (buttons, switches). Each
// channel passes through a two-flop synchronizer, then feeds an up/down
// saturating counter that is only advanced on a shared sample tick. The
// debounced level changes only when the counter reaches a rail (0 or
// PULSE_CNT_MAX), so both press and release are filtered and the band in
// between acts as hysteresis.
//
// Optional feature macro: DEBOUNCER_EDGE_EN
//   defined   : rise_pulse / fall_pulse are registered one-cycle edge pulses
//               aligned with the first cycle of the new debounced level.
//   undefined : edge registers are not built; both pulse outputs read 0.
//               debounced_signal timing is the same in both builds.
//
// Ports:
//   clk              in   1      system clock
//   rst              in   1      synchronous, active-high reset
//   glitchy_signal   in   WIDTH  raw asynchronous inputs
//   debounced_signal out  WIDTH  debounced level per channel
//   rise_pulse       out  WIDTH  one-cycle pulse on debounced 0->1
//   fall_pulse       out  WIDTH  one-cycle pulse on debounced 1->0
// ---------------------------------------------------------------------------
module debouncer_hyst #(
    parameter int WIDTH              = 1,
    parameter int SAMPLE_CNT_MAX     = 25000,
    parameter int PULSE_CNT_MAX      = 150,
    parameter int WRAPPING_CNT_WIDTH = $clog2(SAMPLE_CNT_MAX) + 1,
    parameter int SAT_CNT_WIDTH      = $clog2(PULSE_CNT_MAX) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam logic [WRAPPING_CNT_WIDTH-1:0] SAMPLE_LAST = WRAPPING_CNT_WIDTH'(SAMPLE_CNT_MAX - 1);
    localparam logic [WRAPPING_CNT_WIDTH-1:0] SAMPLE_ONE  = WRAPPING_CNT_WIDTH'(1);
    localparam logic [SAT_CNT_WIDTH-1:0]      CNT_TOP     = SAT_CNT_WIDTH'(PULSE_CNT_MAX);
    localparam logic [SAT_CNT_WIDTH-1:0]      CNT_ONE     = SAT_CNT_WIDTH'(1);
    localparam logic [SAT_CNT_WIDTH-1:0]      CNT_ZERO    = '0;

    logic [WIDTH-1:0]              sync1_q, sync1_d;
    logic [WIDTH-1:0]              sync2_q, sync2_d;
    logic [WRAPPING_CNT_WIDTH-1:0] samp_q, samp_d;
    logic                          tick;
    logic [SAT_CNT_WIDTH-1:0]      cnt_q [WIDTH];
    logic [SAT_CNT_WIDTH-1:0]      cnt_d [WIDTH];
    logic [WIDTH-1:0]              deb_q, deb_d;

    // Synchronizer and shared sample-rate counter.
    always_comb begin
        sync1_d = glitchy_signal;
        sync2_d = sync1_q;
        tick    = (samp_q == SAMPLE_LAST);
        samp_d  = tick ? '0 : (samp_q + SAMPLE_ONE);
    end

    // Per-channel saturating counter and hysteresis level.
    // The level looks at the current counter value, so it moves one cycle
    // after the counter lands on a rail.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (sync2_q[i] && (cnt_q[i] < CNT_TOP)) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else if (!sync2_q[i] && (cnt_q[i] != CNT_ZERO)) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
            if (cnt_q[i] == CNT_TOP) begin
                deb_d[i] = 1'b1;
            end else if (cnt_q[i] == CNT_ZERO) begin
                deb_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            deb_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign debounced_signal = deb_q;

`ifdef DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Registered from the level's next value so the pulse lines up with the
    // first cycle debounced_signal shows the new level.
    always_comb begin
        rise_d = deb_d & ~deb_q;
        fall_d = ~deb_d & deb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_debouncer_hyst.sv
// ---------------------------------------------------------------------------
// tb_debouncer_hyst
//
// Bench for debouncer_hyst with WIDTH=4, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
// A behavioural model (input history queue, tick by cycle arithmetic,
// integer saturating counts) is compared with the DUT every cycle after the
// first reset; directed scenarios add literal latency windows and pulse
// expectations on top.
// ---------------------------------------------------------------------------
module tb_debouncer_hyst;

    localparam int W = 4;
    localparam int S = 4;
    localparam int P = 3;
    localparam int LAT_MIN = 2 + (P - 1) * S + 2;  // 12
    localparam int LAT_MAX = 2 + P * S + 1;        // 15

`ifdef DEBOUNCER_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] glitchy;
    logic [W-1:0] deb;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    debouncer_hyst #(
        .WIDTH          (W),
        .SAMPLE_CNT_MAX (S),
        .PULSE_CNT_MAX  (P)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .glitchy_signal   (glitchy),
        .debounced_signal (deb),
        .rise_pulse       (rise),
        .fall_pulse       (fall)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val >= lo && val <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected within [%0d,%0d]", name, val, lo, hi);
    endtask

    // ---------------- behavioural model ----------------
    // Output of the synchronizer is simply the input two edges ago; the tick
    // is every S-th edge counted from reset; counts are plain clamped integers.
    logic [W-1:0] in_hist[$];
    int           m_cnt[W];
    int           phase;
    logic [W-1:0] m_deb, m_rise, m_fall, m_synced, m_deb_new;
    bit           model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_valid = 1'b1;
            phase       = 0;
            for (int i = 0; i < W; i++) m_cnt[i] = 0;
            m_deb  = '0;
            m_rise = '0;
            m_fall = '0;
            in_hist.delete();
            in_hist.push_back('0);
            in_hist.push_back('0);
        end else if (model_valid) begin
            m_synced = in_hist.pop_front();
            in_hist.push_back(glitchy);
            for (int i = 0; i < W; i++) begin
                if (m_cnt[i] == P)      m_deb_new[i] = 1'b1;
                else if (m_cnt[i] == 0) m_deb_new[i] = 1'b0;
                else                    m_deb_new[i] = m_deb[i];
                if (phase == S - 1) begin
                    if (m_synced[i]) m_cnt[i] = (m_cnt[i] + 1 > P) ? P : m_cnt[i] + 1;
                    else             m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end
            phase  = (phase + 1) % S;
            m_rise = EDGE_EN ? (m_deb_new & ~m_deb) : '0;
            m_fall = EDGE_EN ? (~m_deb_new & m_deb) : '0;
            m_deb  = m_deb_new;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (model_valid && !done) begin
            check("deb_vs_model", 32'(deb), 32'(m_deb));
            check("rise_vs_model", 32'(rise), 32'(m_rise));
            check("fall_vs_model", 32'(fall), 32'(m_fall));
            check("rise_fall_exclusive", 32'(rise & fall), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_level(input int ch, input logic lvl, input int t0, input string name);
        bit   seen;
        int   d;
        logic p;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (deb[ch] == lvl) begin
                seen = 1'b1;
                break;
            end
        end
        d = seen ? (cyc - t0) : -1;
        check_range({name, "_latency"}, d, LAT_MIN, LAT_MAX);
        if (seen) begin
            p = lvl ? rise[ch] : fall[ch];
            check({name, "_pulse"}, 32'(p), 32'(EDGE_EN));
            @(negedge clk);
            p = lvl ? rise[ch] : fall[ch];
            check({name, "_pulse_single"}, 32'(p), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t2, first0, first2, other, hi_cnt, lo_cnt, pul, hold;
        bit got2;

        rst     = 1'b1;
        glitchy = '0;
        repeat (3) @(negedge clk);
        check("reset_deb", 32'(deb), 32'd0);
        check("reset_rise", 32'(rise), 32'd0);
        check("reset_fall", 32'(fall), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: press on channel 0
        glitchy = 4'b0001;
        t0 = cyc;
        wait_level(0, 1'b1, t0, "t1_press");
        repeat (10) @(negedge clk);

        // 2: release on channel 0 from a saturated count
        glitchy = 4'b0000;
        t0 = cyc;
        wait_level(0, 1'b0, t0, "t2_release");
        repeat (20) @(negedge clk);

        // 3a: short high glitch
        glitchy = 4'b0001;
        repeat (6) @(negedge clk);
        glitchy = 4'b0000;
        hi_cnt = 0;
        pul    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            hi_cnt += int'(deb[0]);
            pul    += int'(rise[0] | fall[0]);
        end
        check("t3a_no_assert", 32'(hi_cnt), 32'd0);
        check("t3a_no_pulse", 32'(pul), 32'd0);
        check("t3a_model_cnt_decayed", 32'(m_cnt[0]), 32'd0);

        // 3b: short low glitch while asserted
        glitchy = 4'b0001;
        t0 = cyc;
        wait_level(0, 1'b1, t0, "t3b_press");
        repeat (20) @(negedge clk);
        glitchy = 4'b0000;
        repeat (6) @(negedge clk);
        glitchy = 4'b0001;
        lo_cnt = 0;
        pul    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lo_cnt += int'(!deb[0]);
            pul    += int'(rise[0] | fall[0]);
        end
        check("t3b_no_deassert", 32'(lo_cnt), 32'd0);
        check("t3b_no_pulse", 32'(pul), 32'd0);
        check("t3b_model_deb_high", 32'(m_deb[0]), 32'd1);
        glitchy = 4'b0000;
        t0 = cyc;
        wait_level(0, 1'b0, t0, "t3b_release");
        repeat (20) @(negedge clk);

        // 4: staggered channels 0 and 2
        glitchy = 4'b0001;
        t0     = cyc;
        t2     = 0;
        first0 = -1;
        first2 = -1;
        other  = 0;
        got2   = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 7) begin
                glitchy = 4'b0101;
                t2      = cyc;
                got2    = 1'b1;
            end
            if (first0 < 0 && deb[0]) first0 = cyc;
            if (got2 && first2 < 0 && deb[2]) first2 = cyc;
            other += int'(deb[1] | deb[3] | rise[1] | rise[3]);
            if (first0 >= 0 && first2 >= 0 && k > 30) break;
        end
        check_range("t4_ch0_latency", (first0 < 0) ? -1 : first0 - t0, LAT_MIN, LAT_MAX);
        check_range("t4_ch2_latency", (first2 < 0) ? -1 : first2 - t2, LAT_MIN, LAT_MAX);
        check("t4_ch1_ch3_quiet", 32'(other), 32'd0);
        check("t4_final_level", 32'(deb), 32'b0101);
        glitchy = 4'b0000;
        repeat (30) @(negedge clk);

        // 5: reset in the middle of a press
        glitchy = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_cnt[0] == 2) break;
        end
        check("t5_model_cnt_2", 32'(m_cnt[0]), 32'd2);
        check("t5_not_yet_asserted", 32'(deb), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        check("t5_post_reset_deb", 32'(deb), 32'd0);
        check("t5_post_reset_rise", 32'(rise), 32'd0);
        check("t5_post_reset_fall", 32'(fall), 32'd0);
        wait_level(0, 1'b1, t0, "t5_reassert");
        repeat (10) @(negedge clk);
        glitchy = 4'b0000;
        t0 = cyc;
        wait_level(0, 1'b0, t0, "t5_release");

        // random segments with occasional reset
        for (int seg = 0; seg < 120; seg++) begin
            glitchy = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold = $urandom_range(1, 30);
            repeat (hold) @(negedge clk);
        end

        glitchy = '0;
        repeat (5) @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
